// File: rtl/dispatch_unit_pkg.sv
// Shared constants for the dispatcher, decoder, RS and LSB: default widths,
// op-code encodings and the occupancy helper used by the accept logic.
package dispatch_unit_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int ROB_IDX_W_DEF = 3;
  localparam int NUM_CDB_DEF   = 2;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd6;
  localparam logic [5:0] OP_BEQ  = 6'd7;
  localparam logic [5:0] OP_LW   = 6'd16;
  localparam logic [5:0] OP_SW   = 6'd17;

  // A receiver cannot take a new entry when it is full, or when it has only
  // one free slot left and the entry sitting in the issue register is about
  // to take that slot.
  function automatic logic target_blocked(input logic full,
                                          input logic almost_full,
                                          input logic pending_same);
    return full | (almost_full & pending_same);
  endfunction

endpackage

// File: rtl/dispatch_unit_if.sv
// Decoder-to-dispatcher handshake: one decoded instruction per cycle,
// transferred when in_valid and in_ready are both high.
interface dispatch_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [5:0]      in_op;
  logic            in_is_mem;
  logic            in_use_rs1;
  logic            in_use_rs2;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_pc;

  modport master (
    output in_valid, in_op, in_is_mem, in_use_rs1, in_use_rs2,
           in_rs1, in_rs2, in_rd, in_imm, in_pc,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_is_mem, in_use_rs1, in_use_rs2,
           in_rs1, in_rs2, in_rd, in_imm, in_pc,
    output in_ready
  );
endinterface

// File: rtl/dispatch_unit_operand_resolver.sv
// Combinational source-operand lookup: register file first, then the RoB,
// then the CDB channels (lowest channel wins), otherwise wait on the RF tag.
module operand_resolver #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 3,
  parameter int NUM_CDB   = 2
) (
  input  logic                         use_src,
  input  logic [4:0]                   src_idx,
  input  logic [XLEN-1:0]              rf_val,
  input  logic                         rf_busy,
  input  logic [ROB_IDX_W-1:0]         rf_tag,
  input  logic                         rob_ready,
  input  logic [XLEN-1:0]              rob_val,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]      cdb_val,
  output logic                         src_ready,
  output logic [XLEN-1:0]              src_val,
  output logic [ROB_IDX_W-1:0]         src_tag
);

  logic            cdb_hit;
  logic [XLEN-1:0] cdb_hit_val;

  // Scan channels from highest to lowest so the lowest matching one is kept.
  always_comb begin
    cdb_hit     = 1'b0;
    cdb_hit_val = '0;
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (cdb_valid[i] && (cdb_tag[i*ROB_IDX_W +: ROB_IDX_W] == rf_tag)) begin
        cdb_hit     = 1'b1;
        cdb_hit_val = cdb_val[i*XLEN +: XLEN];
      end
    end
  end

  // Priority chain; a resolved operand carries a zero tag.
  always_comb begin
    src_ready = 1'b0;
    src_val   = '0;
    src_tag   = '0;
    if (!use_src || (src_idx == 5'd0)) begin
      src_ready = 1'b1;
    end else if (!rf_busy) begin
      src_ready = 1'b1;
      src_val   = rf_val;
    end else if (rob_ready) begin
      src_ready = 1'b1;
      src_val   = rob_val;
    end else if (cdb_hit) begin
      src_ready = 1'b1;
      src_val   = cdb_hit_val;
    end else begin
      src_tag   = rf_tag;
    end
  end

endmodule

// File: rtl/dispatch_unit.sv
// Single-issue dispatcher: accepts a decoded instruction, allocates a RoB
// entry, renames rd, resolves both operands and registers the entry for the
// reservation station or load/store buffer.
module dispatch_unit
  import dispatch_unit_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int NUM_CDB   = NUM_CDB_DEF
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  dispatch_unit_if.slave               in_if,
  output logic [4:0]                   rf_rs1_idx,
  output logic [4:0]                   rf_rs2_idx,
  input  logic [XLEN-1:0]              rf_rs1_val,
  input  logic                         rf_rs1_busy,
  input  logic [ROB_IDX_W-1:0]         rf_rs1_tag,
  input  logic [XLEN-1:0]              rf_rs2_val,
  input  logic                         rf_rs2_busy,
  input  logic [ROB_IDX_W-1:0]         rf_rs2_tag,
  output logic [ROB_IDX_W-1:0]         rob_q1_tag,
  output logic [ROB_IDX_W-1:0]         rob_q2_tag,
  input  logic                         rob_q1_ready,
  input  logic [XLEN-1:0]              rob_q1_val,
  input  logic                         rob_q2_ready,
  input  logic [XLEN-1:0]              rob_q2_val,
  input  logic                         rob_full,
  input  logic [ROB_IDX_W-1:0]         rob_alloc_tag,
  output logic                         rob_alloc_valid,
  output logic                         rf_rename_valid,
  output logic [4:0]                   rf_rename_rd,
  output logic [ROB_IDX_W-1:0]         rf_rename_tag,
  input  logic [NUM_CDB-1:0]           cdb_valid,
  input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]      cdb_val,
  input  logic                         rs_full,
  input  logic                         rs_almost_full,
  input  logic                         lsb_full,
  input  logic                         lsb_almost_full,
  output logic                         iss_valid,
  output logic                         iss_to_lsb,
  output logic [5:0]                   iss_op,
  output logic [XLEN-1:0]              iss_vj,
  output logic [XLEN-1:0]              iss_vk,
  output logic [ROB_IDX_W-1:0]         iss_qj,
  output logic [ROB_IDX_W-1:0]         iss_qk,
  output logic                         iss_rj,
  output logic                         iss_rk,
  output logic [XLEN-1:0]              iss_imm,
  output logic [XLEN-1:0]              iss_pc,
  output logic [ROB_IDX_W-1:0]         iss_tag,
  output logic [4:0]                   iss_rd
);

  logic                 res1_ready, res2_ready;
  logic [XLEN-1:0]      res1_val, res2_val;
  logic [ROB_IDX_W-1:0] res1_tag, res2_tag;
  logic                 rs_blocked, lsb_blocked, tgt_blocked;
  logic                 can_accept, accept;

  logic                 iss_valid_q, iss_valid_d;
  logic                 iss_to_lsb_q, iss_to_lsb_d;
  logic [5:0]           iss_op_q, iss_op_d;
  logic [XLEN-1:0]      iss_vj_q, iss_vj_d;
  logic [XLEN-1:0]      iss_vk_q, iss_vk_d;
  logic [ROB_IDX_W-1:0] iss_qj_q, iss_qj_d;
  logic [ROB_IDX_W-1:0] iss_qk_q, iss_qk_d;
  logic                 iss_rj_q, iss_rj_d;
  logic                 iss_rk_q, iss_rk_d;
  logic [XLEN-1:0]      iss_imm_q, iss_imm_d;
  logic [XLEN-1:0]      iss_pc_q, iss_pc_d;
  logic [ROB_IDX_W-1:0] iss_tag_q, iss_tag_d;
  logic [4:0]           iss_rd_q, iss_rd_d;

  assign rf_rs1_idx = in_if.in_rs1;
  assign rf_rs2_idx = in_if.in_rs2;
  assign rob_q1_tag = rf_rs1_tag;
  assign rob_q2_tag = rf_rs2_tag;

  operand_resolver #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .NUM_CDB(NUM_CDB)) u_res_rs1 (
    .use_src   (in_if.in_use_rs1),
    .src_idx   (in_if.in_rs1),
    .rf_val    (rf_rs1_val),
    .rf_busy   (rf_rs1_busy),
    .rf_tag    (rf_rs1_tag),
    .rob_ready (rob_q1_ready),
    .rob_val   (rob_q1_val),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_val   (cdb_val),
    .src_ready (res1_ready),
    .src_val   (res1_val),
    .src_tag   (res1_tag)
  );

  operand_resolver #(.XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .NUM_CDB(NUM_CDB)) u_res_rs2 (
    .use_src   (in_if.in_use_rs2),
    .src_idx   (in_if.in_rs2),
    .rf_val    (rf_rs2_val),
    .rf_busy   (rf_rs2_busy),
    .rf_tag    (rf_rs2_tag),
    .rob_ready (rob_q2_ready),
    .rob_val   (rob_q2_val),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_val   (cdb_val),
    .src_ready (res2_ready),
    .src_val   (res2_val),
    .src_tag   (res2_tag)
  );

  // Accept when enabled, not flushing, RoB has room and the target has room
  // even after the entry already waiting in the issue register lands.
  always_comb begin
    rs_blocked      = target_blocked(rs_full, rs_almost_full, iss_valid_q & ~iss_to_lsb_q);
    lsb_blocked     = target_blocked(lsb_full, lsb_almost_full, iss_valid_q & iss_to_lsb_q);
    tgt_blocked     = in_if.in_is_mem ? lsb_blocked : rs_blocked;
    can_accept      = rdy_in & ~flush_in & ~rob_full & ~tgt_blocked;
    accept          = in_if.in_valid & can_accept;
    in_if.in_ready  = can_accept;
    rob_alloc_valid = accept;
    rf_rename_valid = accept & (in_if.in_rd != 5'd0);
    rf_rename_rd    = in_if.in_rd;
    rf_rename_tag   = rob_alloc_tag;
  end

  // Issue register next state: load on accept, drop valid otherwise, and
  // hold everything while the core is stalled.
  always_comb begin
    iss_valid_d  = iss_valid_q;
    iss_to_lsb_d = iss_to_lsb_q;
    iss_op_d     = iss_op_q;
    iss_vj_d     = iss_vj_q;
    iss_vk_d     = iss_vk_q;
    iss_qj_d     = iss_qj_q;
    iss_qk_d     = iss_qk_q;
    iss_rj_d     = iss_rj_q;
    iss_rk_d     = iss_rk_q;
    iss_imm_d    = iss_imm_q;
    iss_pc_d     = iss_pc_q;
    iss_tag_d    = iss_tag_q;
    iss_rd_d     = iss_rd_q;
    if (rdy_in) begin
      iss_valid_d = accept;
      if (accept) begin
        iss_to_lsb_d = in_if.in_is_mem;
        iss_op_d     = in_if.in_op;
        iss_vj_d     = res1_val;
        iss_vk_d     = res2_val;
        iss_qj_d     = res1_tag;
        iss_qk_d     = res2_tag;
        iss_rj_d     = res1_ready;
        iss_rk_d     = res2_ready;
        iss_imm_d    = in_if.in_imm;
        iss_pc_d     = in_if.in_pc;
        iss_tag_d    = rob_alloc_tag;
        iss_rd_d     = in_if.in_rd;
      end
    end
  end

  // Issue register flops, cleared asynchronously on reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      iss_valid_q  <= 1'b0;
      iss_to_lsb_q <= 1'b0;
      iss_op_q     <= '0;
      iss_vj_q     <= '0;
      iss_vk_q     <= '0;
      iss_qj_q     <= '0;
      iss_qk_q     <= '0;
      iss_rj_q     <= 1'b0;
      iss_rk_q     <= 1'b0;
      iss_imm_q    <= '0;
      iss_pc_q     <= '0;
      iss_tag_q    <= '0;
      iss_rd_q     <= '0;
    end else begin
      iss_valid_q  <= iss_valid_d;
      iss_to_lsb_q <= iss_to_lsb_d;
      iss_op_q     <= iss_op_d;
      iss_vj_q     <= iss_vj_d;
      iss_vk_q     <= iss_vk_d;
      iss_qj_q     <= iss_qj_d;
      iss_qk_q     <= iss_qk_d;
      iss_rj_q     <= iss_rj_d;
      iss_rk_q     <= iss_rk_d;
      iss_imm_q    <= iss_imm_d;
      iss_pc_q     <= iss_pc_d;
      iss_tag_q    <= iss_tag_d;
      iss_rd_q     <= iss_rd_d;
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_to_lsb = iss_to_lsb_q;
  assign iss_op     = iss_op_q;
  assign iss_vj     = iss_vj_q;
  assign iss_vk     = iss_vk_q;
  assign iss_qj     = iss_qj_q;
  assign iss_qk     = iss_qk_q;
  assign iss_rj     = iss_rj_q;
  assign iss_rk     = iss_rk_q;
  assign iss_imm    = iss_imm_q;
  assign iss_pc     = iss_pc_q;
  assign iss_tag    = iss_tag_q;
  assign iss_rd     = iss_rd_q;

endmodule
